// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory port, req/gnt then rvalid response.
// master = load/store unit, slave = data memory.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: IDLE->REQ->(RESP)->DONE load/store sequencer.
// Define LSU_MISALIGN_TRAP_EN to drop misaligned half/word accesses.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_req_i,
  input  logic                      data_wr_i,
  input  logic [1:0]                data_byte_i,
  input  logic                      zero_extnd_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wr_data_i,
  load_store_unit_if.master         mem,
  output logic                      stall_o,
  output logic                      rd_valid_o,
  output logic [31:0]               rd_data_o,
  output logic                      err_o,
  output logic                      misaligned_o
);
  typedef enum logic [1:0] {
    IDLE, REQ, RESP, DONE
  } state_t;

  localparam logic [31:0] LAST =
    32'(TIMEOUT - 1);

  state_t      state;
  logic        byte_q;
  logic        half_q;
  logic        ext_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] ld_val;
  logic        timeout;

  assign is_word = data_byte_i[1];
  assign is_half = data_byte_i == 2'b01;
  assign is_byte = data_byte_i == 2'b00;

  always_comb begin
    off   = addr_i[1:0];
    strb  = 4'b0000;
    wdata = wr_data_i;
    unique case (1'b1)
      is_word: begin
        off  = 2'b00;
        strb = 4'b1111;
      end
      is_half: begin
        off   = {addr_i[1], 1'b0};
        strb  = 4'b0011 << off;
        wdata = {2{wr_data_i[15:0]}};
      end
      is_byte: begin
        strb  = 4'b0001 << off;
        wdata = {4{wr_data_i[7:0]}};
      end
      default: ;
    endcase
    if (!data_wr_i) strb = 4'b0000;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic bad;
  assign bad = (is_half && addr_i[0]) ||
               (is_word && addr_i[1:0] != 2'b00);
`else
  assign misaligned_o = 1'b0;
`endif

  always_comb begin
    shifted = mem.rdata >> {off_q, 3'b000};
    ld_val  = shifted;
    if (byte_q)
      ld_val = {{24{~ext_q & shifted[7]}},
                shifted[7:0]};
    else if (half_q)
      ld_val = {{16{~ext_q & shifted[15]}},
                shifted[15:0]};
  end

  assign timeout = (TIMEOUT != 0) &&
                   (cnt == LAST);

  // stall is released in DONE so the op retires
  assign stall_o = !reset &&
    ((state == IDLE) ? data_req_i
                     : (state != DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem.req    <= 1'b0;
      mem.we     <= 1'b0;
      mem.addr   <= '0;
      mem.wstrb  <= '0;
      mem.wdata  <= '0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      ext_q      <= 1'b0;
      off_q      <= '0;
      cnt        <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      err_o      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_o <= 1'b0;
`endif
    end else begin
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_o <= 1'b0;
`endif
      unique case (state)
        IDLE: if (data_req_i) begin
          byte_q    <= is_byte;
          half_q    <= is_half;
          ext_q     <= zero_extnd_i;
          off_q     <= off;
          cnt       <= '0;
          mem.we    <= data_wr_i;
          mem.addr  <= {addr_i[31:2], 2'b00};
          mem.wstrb <= strb;
          mem.wdata <= wdata;
`ifdef LSU_MISALIGN_TRAP_EN
          if (bad) begin
            misaligned_o <= 1'b1;
            state        <= DONE;
          end else begin
            mem.req <= 1'b1;
            state   <= REQ;
          end
`else
          mem.req <= 1'b1;
          state   <= REQ;
`endif
        end
        REQ: begin
          if (mem.gnt) begin
            mem.req <= 1'b0;
            cnt     <= '0;
            state   <= mem.we ? DONE : RESP;
          end else if (timeout) begin
            mem.req <= 1'b0;
            err_o   <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP: begin
          if (mem.rvalid) begin
            rd_data_o  <= ld_val;
            rd_valid_o <= 1'b1;
            state      <= DONE;
          end else if (timeout) begin
            err_o <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors with a scripted
// memory responder; DUT built with TIMEOUT=8.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_byte;
  logic        zero_extnd;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;
  logic        misaligned;

  always #5 clk = ~clk;

  load_store_unit_if mem();

  load_store_unit #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_req_i   (data_req),
    .data_wr_i    (data_wr),
    .data_byte_i  (data_byte),
    .zero_extnd_i (zero_extnd),
    .addr_i       (addr),
    .wr_data_i    (wr_data),
    .mem          (mem),
    .stall_o      (stall),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .err_o        (err),
    .misaligned_o (misaligned)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  int          r_cyc, r_stall, r_rdv;
  int          r_err, r_mis, r_reqs;
  logic [31:0] r_res, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we, r_stable, r_done;
  logic        r_post;

  task automatic run_op(input logic wr,
                        input logic [1:0] sz,
                        input logic ext,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int gnt_wait,
                        input int rv_wait,
                        input logic [31:0] rdata);
    bit granted = 0;
    int k = 0;
    r_cyc = 0; r_stall = 0; r_rdv = 0;
    r_err = 0; r_mis = 0; r_reqs = 0;
    r_res = '0; r_addr = '0;
    r_wdata = '0; r_wstrb = '0;
    r_we = 0; r_stable = 1; r_done = 0;
    data_req = 1; data_wr = wr;
    data_byte = sz; zero_extnd = ext;
    addr = a; wr_data = d;
    mem.rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      r_cyc = c + 1;
      if (stall) r_stall++;
      if (rd_valid) begin
        r_rdv++;
        r_res = rd_data;
      end
      if (err) r_err++;
      if (misaligned) r_mis++;
      if (mem.req) begin
        r_reqs++;
        if (r_reqs == 1) begin
          r_addr  = mem.addr;
          r_wstrb = mem.wstrb;
          r_wdata = mem.wdata;
          r_we    = mem.we;
        end else if (mem.addr !== r_addr ||
                     mem.wstrb !== r_wstrb ||
                     mem.wdata !== r_wdata ||
                     mem.we !== r_we) begin
          r_stable = 0;
        end
      end
      if (c > 0 && !stall) begin
        r_done = 1;
        mem.gnt = 0;
        mem.rvalid = 0;
        data_req = 0;
        break;
      end
      if (granted) k++;
      mem.rvalid = granted &&
                   (k == rv_wait + 1);
      mem.gnt = mem.req && gnt_wait >= 0 &&
                r_reqs > gnt_wait;
      if (mem.gnt) granted = 1;
      @(posedge clk);
      #1;
    end
    data_req = 0;
    mem.gnt = 0;
    mem.rvalid = 0;
    @(posedge clk);
    #2;
    r_post = rd_valid | err | misaligned |
             stall | mem.req;
  endtask

  initial begin
    reset = 1; data_req = 0; data_wr = 0;
    data_byte = 0; zero_extnd = 0;
    addr = '0; wr_data = '0;
    mem.gnt = 0; mem.rvalid = 0;
    mem.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem.req, 0);
    chk("rst_we", mem.we, 0);
    chk("rst_addr", mem.addr, 0);
    chk("rst_wstrb", mem.wstrb, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_err", err, 0);
    chk("rst_mis", misaligned, 0);
    reset = 0;
    @(posedge clk);
    #1;

    // LB sign-extended from lane 3
    run_op(0, 2'b00, 0, 32'h103, 0, 0, 0,
           32'h80FF1234);
    chk("lb_done", r_done, 1);
    chk("lb_res", r_res, 32'hFFFFFF80);
    chk("lb_rdv", r_rdv, 1);
    chk("lb_cyc", r_cyc, 4);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_wstrb", r_wstrb, 0);
    chk("lb_post", r_post, 0);

    run_op(0, 2'b00, 1, 32'h103, 0, 0, 0,
           32'h80FF1234);
    chk("lbu_res", r_res, 32'h00000080);
    chk("lbu_rdv", r_rdv, 1);

    run_op(0, 2'b01, 0, 32'h102, 0, 0, 1,
           32'h80010000);
    chk("lh_res", r_res, 32'hFFFF8001);
    chk("lh_cyc", r_cyc, 5);
    run_op(0, 2'b01, 1, 32'h102, 0, 0, 0,
           32'h80010000);
    chk("lhu_res", r_res, 32'h00008001);

    run_op(1, 2'b01, 0, 32'h202,
           32'h0000ABCD, 0, 0, 0);
    chk("sh_addr", r_addr, 32'h200);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_wstrb", r_wstrb, 4'b1100);
    chk("sh_we", r_we, 1);
    chk("sh_stall", r_stall, 2);
    chk("sh_cyc", r_cyc, 3);
    chk("sh_rdv", r_rdv, 0);
    chk("sh_post", r_post, 0);

    run_op(1, 2'b00, 0, 32'h1,
           32'h1234565A, 0, 0, 0);
    chk("sb_wdata", r_wdata, 32'h5A5A5A5A);
    chk("sb_wstrb", r_wstrb, 4'b0010);
    run_op(1, 2'b11, 0, 32'h10,
           32'hCAFEF00D, 0, 0, 0);
    chk("sw3_wdata", r_wdata, 32'hCAFEF00D);
    chk("sw3_wstrb", r_wstrb, 4'b1111);

    run_op(0, 2'b10, 0, 32'h40, 0, 3, 0,
           32'hDEADBEEF);
    chk("lw_wait_reqs", r_reqs, 4);
    chk("lw_wait_stable", r_stable, 1);
    chk("lw_wait_stall", r_stall, 6);
    chk("lw_wait_res", r_res, 32'hDEADBEEF);
    chk("lw_wait_cyc", r_cyc, 7);

    run_op(0, 2'b10, 0, 32'h40, 0, -1, 0,
           32'h0);
    chk("to_done", r_done, 1);
    chk("to_err", r_err, 1);
    chk("to_reqs", r_reqs, 8);
    chk("to_cyc", r_cyc, 10);
    chk("to_rdv", r_rdv, 0);
    chk("to_post", r_post, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    run_op(0, 2'b10, 0, 32'h101, 0, 0, 0,
           32'h11223344);
    chk("mis_pulse", r_mis, 1);
    chk("mis_reqs", r_reqs, 0);
    chk("mis_rdv", r_rdv, 0);
    chk("mis_cyc", r_cyc, 2);
`else
    run_op(0, 2'b10, 0, 32'h101, 0, 0, 0,
           32'h11223344);
    chk("mis_addr", r_addr, 32'h100);
    chk("mis_wstrb", r_wstrb, 0);
    chk("mis_res", r_res, 32'h11223344);
    chk("mis_flag", r_mis, 0);
`endif

    // reset while waiting for rvalid
    data_req = 1; data_wr = 0;
    data_byte = 2'b10; addr = 32'h80;
    @(posedge clk);
    #1;
    mem.gnt = 1;
    @(posedge clk);
    #1;
    mem.gnt = 0;
    reset = 1;
    #1;
    chk("rr_req", mem.req, 0);
    chk("rr_stall", stall, 0);
    chk("rr_rdata", rd_data, 0);
    data_req = 0;
    @(posedge clk);
    #1;
    reset = 0;
    mem.rvalid = 1;
    mem.rdata = 32'h55555555;
    @(posedge clk);
    #1;
    mem.rvalid = 0;
    chk("rr_rdv", rd_valid, 0);
    chk("rr_rdata2", rd_data, 0);
    run_op(0, 2'b10, 0, 32'h84, 0, 0, 0,
           32'h13579BDF);
    chk("rr_next_res", r_res, 32'h13579BDF);
    chk("rr_next_cyc", r_cyc, 4);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule
